// File: rtl/rxll_rd_sched_if.sv
// rtl/rxll_rd_sched_if.sv - RX FIFO read side, DMA sink, ififo sink and frame status bundle
interface rxll_rd_sched_if;
    logic        rd_empty;
    logic [35:0] rd_do;
    logic        rd_eof_rdy;
    logic        rd_en;
    logic        dma_valid;
    logic [31:0] dma_data;
    logic        dma_last;
    logic        dma_ready;
    logic        ififo_wr_en;
    logic [31:0] ififo_data;
    logic        ififo_last;
    logic        ififo_full;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_len;
    logic        busy;

    modport master (
        input  rd_empty, rd_do, rd_eof_rdy, dma_ready, ififo_full,
        output rd_en, dma_valid, dma_data, dma_last, ififo_wr_en, ififo_data,
               ififo_last, frame_done, frame_err, frame_len, busy
    );

    modport slave (
        output rd_empty, rd_do, rd_eof_rdy, dma_ready, ififo_full,
        input  rd_en, dma_valid, dma_data, dma_last, ififo_wr_en, ififo_data,
               ififo_last, frame_done, frame_err, frame_len, busy
    );
endinterface

// File: rtl/rxll_rd_sched.sv
// rtl/rxll_rd_sched.sv - RX link-layer read sequencer routing frames to DMA or ififo
module rxll_rd_sched #(
    parameter int unsigned C_MAX_DW   = 2049,
    parameter logic [7:0]  C_DATA_FIS = 8'h46
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    rxll_rd_sched_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_DMA  = 3'd2;
    localparam logic [2:0] S_IFIS = 3'd3;
    localparam logic [2:0] S_DROP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [16:0] MAX_DW = 17'(C_MAX_DW);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] frame_len_q;

    logic        pop;
    logic        dma_valid, dma_last, ififo_wr_en, ififo_last;
    logic        sof, eof, crc, over;
    logic [15:0] cnt_inc;
    logic        unused_rsvd;

    assign sof         = bus.rd_do[32];
    assign eof         = bus.rd_do[33];
    assign crc         = bus.rd_do[34];
    assign unused_rsvd = bus.rd_do[35];
    // A pop at this count would push the frame past C_MAX_DW.
    assign over    = ({1'b0, cnt_q} >= MAX_DW);
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        pop         = 1'b0;
        dma_valid   = 1'b0;
        dma_last    = 1'b0;
        ififo_wr_en = 1'b0;
        ififo_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (bus.rd_eof_rdy && !bus.rd_empty) state_d = S_HDR;
            end
            S_HDR: if (!bus.rd_empty) begin
                if (!sof) begin
                    err_d   = 1'b1;
                    state_d = S_DROP;
                end else if (bus.rd_do[7:0] == C_DATA_FIS) begin
                    pop = 1'b1;
                    if (eof) begin
                        state_d = S_DONE;
                        if (crc) err_d = 1'b1;
                    end else begin
                        state_d = S_DMA;
                    end
                end else if (!bus.ififo_full) begin
                    pop         = 1'b1;
                    ififo_wr_en = 1'b1;
                    ififo_last  = eof;
                    if (eof) begin
                        state_d = S_DONE;
                        if (crc) err_d = 1'b1;
                    end else begin
                        state_d = S_IFIS;
                    end
                end
            end
            S_DMA, S_IFIS: if (!bus.rd_empty) begin
                // A new SOF mid-frame is left in the FIFO as the next header.
                if (sof) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (over) begin
                    pop     = 1'b1;
                    err_d   = 1'b1;
                    state_d = eof ? S_DONE : S_DROP;
                end else if (state_q == S_DMA) begin
                    dma_valid = 1'b1;
                    dma_last  = eof;
                    pop       = bus.dma_ready;
                end else if (!bus.ififo_full) begin
                    ififo_wr_en = 1'b1;
                    ififo_last  = eof;
                    pop         = 1'b1;
                end
                if (pop && eof && !over) begin
                    state_d = S_DONE;
                    if (crc) err_d = 1'b1;
                end
            end
            S_DROP: if (!bus.rd_empty) begin
                pop = 1'b1;
                if (eof) state_d = S_DONE;
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) cnt_d = cnt_inc;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            frame_len_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == S_DONE) frame_len_q <= cnt_q;
        end
    end

    assign bus.rd_en       = pop;
    assign bus.dma_valid   = dma_valid;
    assign bus.dma_data    = bus.rd_do[31:0];
    assign bus.dma_last    = dma_last;
    assign bus.ififo_wr_en = ififo_wr_en;
    assign bus.ififo_data  = bus.rd_do[31:0];
    assign bus.ififo_last  = ififo_last;
    assign bus.frame_done  = (state_q == S_DONE);
    assign bus.frame_err   = (state_q == S_DONE) && err_q;
    assign bus.frame_len   = (state_q == S_DONE) ? cnt_q : frame_len_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_rxll_rd_sched.sv
// tb/tb_rxll_rd_sched.sv - scoreboard bench for rxll_rd_sched
module tb_rxll_rd_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rxll_rd_sched_if bus();

    rxll_rd_sched #(.C_MAX_DW(8), .C_DATA_FIS(8'h46)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (bus)
    );

    logic [35:0] fifo[$];
    logic [32:0] exp_dma[$], obs_dma[$];
    logic [32:0] exp_ifi[$], obs_ifi[$];
    logic [16:0] exp_done[$], obs_done[$];
    int tests = 0;
    int fails = 0;
    int viol  = 0;
    int cyc   = 0;
    int ready_mode = 0;
    int full_start = -1;
    int full_len   = 0;

    function automatic logic [35:0] w(input logic [31:0] d, input bit s, input bit e, input bit c);
        return {1'b0, c, e, s, d};
    endfunction

    task automatic step();
        bit any_eof;
        bit popping;
        @(negedge clk);
        any_eof = 1'b0;
        foreach (fifo[i]) if (fifo[i][33]) any_eof = 1'b1;
        bus.rd_empty   = (fifo.size() == 0);
        bus.rd_do      = (fifo.size() == 0) ? 36'h0 : fifo[0];
        bus.rd_eof_rdy = any_eof;
        bus.dma_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? cyc[0] : 1'b0;
        bus.ififo_full = (cyc >= full_start) && (cyc < full_start + full_len);
        #1;
        if (bus.rd_en && bus.rd_empty) viol++;
        if (bus.rd_en && bus.dma_valid && !bus.dma_ready) viol++;
        if (bus.dma_valid && bus.dma_ready) obs_dma.push_back({bus.dma_last, bus.dma_data});
        if (bus.ififo_wr_en) obs_ifi.push_back({bus.ififo_last, bus.ififo_data});
        if (bus.frame_done) obs_done.push_back({bus.frame_err, bus.frame_len});
        popping = bus.rd_en;
        @(posedge clk);
        if (popping && fifo.size() != 0) void'(fifo.pop_front());
        cyc++;
    endtask

    task automatic run_until(input int ndone, input string name);
        int budget = 300;
        while (obs_done.size() < ndone && budget > 0) begin
            step();
            budget--;
        end
        step();
        tests++;
        if (budget == 0) begin
            fails++;
            $display("FAIL %s_timeout: frame_done count %0d, required %0d", name, obs_done.size(), ndone);
        end
    endtask

    task automatic clear_sb();
        exp_dma.delete(); obs_dma.delete();
        exp_ifi.delete(); obs_ifi.delete();
        exp_done.delete(); obs_done.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        #1;
        tests++;
        if ({bus.rd_en, bus.dma_valid, bus.dma_last, bus.ififo_wr_en, bus.ififo_last,
             bus.frame_done, bus.frame_err, bus.busy, bus.frame_len} !== 24'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%h, required all zero",
                     {bus.rd_en, bus.dma_valid, bus.dma_last, bus.ififo_wr_en, bus.ififo_last,
                      bus.frame_done, bus.frame_err, bus.busy}, bus.frame_len);
        end
        rst = 1'b0;
    endtask

    task automatic test_data_fis(input int mode, input string name);
        clear_sb();
        ready_mode = mode;
        viol = 0;
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            fifo.push_back(w(32'hA000_0000 + 32'(mode * 16 + i), 0, i == 3, 0));
            exp_dma.push_back({i == 3, 32'hA000_0000 + 32'(mode * 16 + i)});
        end
        exp_done.push_back({1'b0, 16'd5});
        run_until(1, name);
        tests++;
        if (obs_dma.size() != exp_dma.size()) begin
            fails++;
            $display("FAIL %s_dma_count: got %0d, required %0d", name, obs_dma.size(), exp_dma.size());
        end
        foreach (exp_dma[i]) begin
            tests++;
            if (obs_dma[i] !== exp_dma[i]) begin
                fails++;
                $display("FAIL %s_dma[%0d]: got %h, required %h", name, i, obs_dma[i], exp_dma[i]);
            end
        end
        tests++;
        if (obs_done.size() != 1 || obs_done[0] !== exp_done[0] || viol != 0) begin
            fails++;
            $display("FAIL %s_status: got %h (n=%0d viol=%0d), required %h", name, obs_done[0], obs_done.size(), viol, exp_done[0]);
        end
        ready_mode = 0;
    endtask

    task automatic test_reg_fis();
        clear_sb();
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] d = (i == 0) ? 32'h0000_0034 : 32'hB000_0000 + 32'(i);
            fifo.push_back(w(d, i == 0, i == 4, 0));
            exp_ifi.push_back({i == 4, d});
        end
        exp_done.push_back({1'b0, 16'd5});
        full_start = cyc + 3;
        full_len   = 3;
        run_until(1, "reg_fis");
        full_start = -1;
        tests++;
        if (obs_ifi.size() != exp_ifi.size() || obs_dma.size() != 0) begin
            fails++;
            $display("FAIL reg_fis_count: got ififo %0d dma %0d, required %0d 0", obs_ifi.size(), obs_dma.size(), exp_ifi.size());
        end
        foreach (exp_ifi[i]) begin
            tests++;
            if (obs_ifi[i] !== exp_ifi[i]) begin
                fails++;
                $display("FAIL reg_fis_ififo[%0d]: got %h, required %h", i, obs_ifi[i], exp_ifi[i]);
            end
        end
        tests++;
        if (obs_done.size() != 1 || obs_done[0] !== exp_done[0] || viol != 0) begin
            fails++;
            $display("FAIL reg_fis_status: got %h (viol=%0d), required %h", obs_done[0], viol, exp_done[0]);
        end
    endtask

    task automatic test_max_len();
        clear_sb();
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        for (int i = 1; i < 12; i++) begin
            fifo.push_back(w(32'hC000_0000 + 32'(i), 0, i == 11, 0));
            if (i <= 7) exp_dma.push_back({1'b0, 32'hC000_0000 + 32'(i)});
        end
        exp_done.push_back({1'b1, 16'd12});
        run_until(1, "max_len");
        tests++;
        if (obs_dma.size() != exp_dma.size()) begin
            fails++;
            $display("FAIL max_len_dma_count: got %0d, required %0d", obs_dma.size(), exp_dma.size());
        end
        foreach (exp_dma[i]) begin
            tests++;
            if (obs_dma[i] !== exp_dma[i]) begin
                fails++;
                $display("FAIL max_len_dma[%0d]: got %h, required %h", i, obs_dma[i], exp_dma[i]);
            end
        end
        tests++;
        if (obs_done.size() != 1 || obs_done[0] !== exp_done[0] || fifo.size() != 0) begin
            fails++;
            $display("FAIL max_len_status: got %h fifo=%0d, required %h fifo=0", obs_done[0], fifo.size(), exp_done[0]);
        end
    endtask

    task automatic test_errors();
        clear_sb();
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        fifo.push_back(w(32'hD000_0001, 0, 0, 0));
        fifo.push_back(w(32'hD000_0002, 0, 1, 1));
        exp_dma.push_back({1'b0, 32'hD000_0001});
        exp_dma.push_back({1'b1, 32'hD000_0002});
        exp_done.push_back({1'b1, 16'd3});
        fifo.push_back(w(32'h0000_0034, 0, 0, 0));
        fifo.push_back(w(32'hD000_0011, 0, 0, 0));
        fifo.push_back(w(32'hD000_0012, 0, 1, 0));
        exp_done.push_back({1'b1, 16'd3});
        run_until(2, "errors");
        tests++;
        if (obs_dma.size() != 2 || obs_dma[0] !== exp_dma[0] || obs_dma[1] !== exp_dma[1] || obs_ifi.size() != 0) begin
            fails++;
            $display("FAIL errors_sinks: got dma n=%0d %h %h ififo n=%0d, required %h %h", obs_dma.size(), obs_dma[0], obs_dma[1], obs_ifi.size(), exp_dma[0], exp_dma[1]);
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (obs_done[i] !== exp_done[i]) begin
                fails++;
                $display("FAIL errors_status[%0d]: got %h, required %h", i, obs_done[i], exp_done[i]);
            end
        end
    endtask

    task automatic test_back_to_back_sof();
        clear_sb();
        viol = 0;
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        fifo.push_back(w(32'hE000_0001, 0, 0, 0));
        fifo.push_back(w(32'hE000_0002, 0, 0, 0));
        exp_dma.push_back({1'b0, 32'hE000_0001});
        exp_dma.push_back({1'b0, 32'hE000_0002});
        exp_done.push_back({1'b1, 16'd3});
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        fifo.push_back(w(32'hE000_0011, 0, 0, 0));
        fifo.push_back(w(32'hE000_0012, 0, 1, 0));
        exp_dma.push_back({1'b0, 32'hE000_0011});
        exp_dma.push_back({1'b1, 32'hE000_0012});
        exp_done.push_back({1'b0, 16'd3});
        run_until(2, "b2b");
        tests++;
        if (obs_dma.size() != exp_dma.size()) begin
            fails++;
            $display("FAIL b2b_dma_count: got %0d, required %0d", obs_dma.size(), exp_dma.size());
        end
        foreach (exp_dma[i]) begin
            tests++;
            if (obs_dma[i] !== exp_dma[i]) begin
                fails++;
                $display("FAIL b2b_dma[%0d]: got %h, required %h", i, obs_dma[i], exp_dma[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (obs_done[i] !== exp_done[i]) begin
                fails++;
                $display("FAIL b2b_status[%0d]: got %h, required %h", i, obs_done[i], exp_done[i]);
            end
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL b2b_rd_en_rules: got %0d violations, required 0", viol);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_sb();
        ready_mode = 2;
        fifo.push_back(w(32'h0000_0046, 1, 0, 0));
        fifo.push_back(w(32'hF000_0001, 0, 0, 0));
        fifo.push_back(w(32'hF000_0002, 0, 1, 0));
        for (int i = 0; i < 4; i++) step();
        tests++;
        if (bus.busy !== 1'b1 || fifo.size() != 2) begin
            fails++;
            $display("FAIL midrst_in_dma: got busy=%b fifo=%0d, required busy=1 fifo=2", bus.busy, fifo.size());
        end
        rst = 1'b1;
        step();
        #1;
        tests++;
        if ({bus.rd_en, bus.dma_valid, bus.dma_last, bus.ififo_wr_en, bus.ififo_last,
             bus.frame_done, bus.frame_err, bus.busy} !== 8'h0 || obs_done.size() != 0 || fifo.size() != 2) begin
            fails++;
            $display("FAIL midrst_outputs: got %b done=%0d fifo=%0d, required 0 0 2",
                     {bus.rd_en, bus.dma_valid, bus.dma_last, bus.ififo_wr_en, bus.ififo_last,
                      bus.frame_done, bus.frame_err, bus.busy}, obs_done.size(), fifo.size());
        end
        rst = 1'b0;
        fifo.delete();
        ready_mode = 0;
        step();
    endtask

    initial begin
        bus.rd_empty   = 1'b1;
        bus.rd_do      = '0;
        bus.rd_eof_rdy = 1'b0;
        bus.dma_ready  = 1'b1;
        bus.ififo_full = 1'b0;
        test_reset();
        test_data_fis(0, "data_fis");
        test_data_fis(1, "data_fis_bp");
        test_reg_fis();
        test_max_len();
        test_errors();
        test_back_to_back_sof();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
